// File: rtl/lfsr_round_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_round_sequencer_pkg
//  Description : Shared types and constants for the memory-game sequencer:
//                controller state encoding, LFSR taps/reset value and the
//                single-step Galois LFSR function.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_round_sequencer_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHOW_LOAD  = 3'd1,
    SHOW       = 3'd2,
    INPUT_LOAD = 3'd3,
    INPUT      = 3'd4,
    ROUND_OK   = 3'd5,
    OVER       = 3'd6
  } state_e;

  // Bit 15 feeds back into bits 2, 3 and 5 (and wraps into bit 0)
  localparam logic [15:0] LFSR_TAPS  = 16'h002C;
  localparam logic [15:0] LFSR_RESET = 16'h0001;

  // One left-shifting Galois step: x^16 + x^5 + x^3 + x^2 + 1
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15]} ^ (x[15] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_round_sequencer_lfsr16_load.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16_load
//  Description : 16-bit Galois LFSR with parallel load and step enable.
//                Load takes priority over step.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16_load
  import lfsr_round_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_step,
  output logic [15:0] o_q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Select load value, stepped value or hold
  always_comb begin
    lfsr_d = lfsr_q;
    if (i_load) begin
      lfsr_d = i_load_val;
    end else if (i_step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR register, never allowed to reset to the all-zero lock-up state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_RESET;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_round_sequencer
//  Description : Two-player memory game controller. Captures a seed from a
//                free-running LFSR at game start, replays the seeded symbol
//                sequence for display and for each player's input check,
//                enforces a per-symbol timeout and reports the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_round_sequencer
  import lfsr_round_sequencer_pkg::*;
#(
  parameter int SYM_W         = 2,
  parameter int MAX_LEN       = 16,
  parameter int SHOW_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 8,
  parameter int LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             btn_valid,
  input  logic [SYM_W-1:0] btn_sym,
  output logic             show_valid,
  output logic [SYM_W-1:0] show_sym,
  output logic             expect_input,
  output logic             player,
  output logic [LEN_W-1:0] round_len,
  output logic             round_done,
  output logic             game_over,
  output logic             loser,
  output logic             timeout_flag,
  output logic             draw
);

  // Timer must count up to the larger of the two tick limits
  localparam int TMR_MAX = (SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SHOW_LAST    = TMR_W'(SHOW_TICKS - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_TICKS - 1);
  localparam logic [LEN_W-1:0] LEN_ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX      = LEN_W'(MAX_LEN);

  state_e           state_q,     state_d;
  logic [15:0]      seed_q,      seed_d;
  logic [LEN_W-1:0] idx_q,       idx_d;
  logic [TMR_W-1:0] timer_q,     timer_d;
  logic [LEN_W-1:0] round_len_q, round_len_d;
  logic             player_q,    player_d;
  logic             loser_q,     loser_d;
  logic             timeout_q,   timeout_d;
  logic             draw_q,      draw_d;

  logic             lfsr_load;
  logic [15:0]      lfsr_load_val;
  logic             lfsr_step;
  logic [15:0]      lfsr;
  logic             last_idx;
  logic [SYM_W-1:0] cur_sym;

  lfsr16_load u_lfsr (
    .clk        (clock),
    .rst        (reset),
    .i_load     (lfsr_load),
    .i_load_val (lfsr_load_val),
    .i_step     (lfsr_step),
    .o_q        (lfsr)
  );

  assign cur_sym  = lfsr[SYM_W-1:0];
  assign last_idx = (idx_q == (round_len_q - LEN_ONE));

  // Next-state, counter and LFSR control decode
  always_comb begin
    state_d       = state_q;
    seed_d        = seed_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    round_len_d   = round_len_q;
    player_d      = player_q;
    loser_d       = loser_q;
    timeout_d     = timeout_q;
    draw_d        = draw_q;
    lfsr_load     = 1'b0;
    lfsr_load_val = lfsr_next(seed_q);
    lfsr_step     = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        // LFSR free-runs here so the seed depends on when start arrives
        lfsr_step = 1'b1;
        if (start) begin
          seed_d      = lfsr;
          round_len_d = LEN_ONE;
          player_d    = 1'b0;
          loser_d     = 1'b0;
          timeout_d   = 1'b0;
          draw_d      = 1'b0;
          state_d     = SHOW_LOAD;
        end
      end

      SHOW_LOAD: begin
        lfsr_load = 1'b1;
        idx_d     = '0;
        timer_d   = '0;
        state_d   = SHOW;
      end

      SHOW: begin
        if (tick) begin
          if (timer_q == SHOW_LAST) begin
            if (last_idx) begin
              state_d = INPUT_LOAD;
            end else begin
              idx_d     = idx_q + LEN_ONE;
              lfsr_step = 1'b1;
              timer_d   = '0;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      INPUT_LOAD: begin
        lfsr_load = 1'b1;
        idx_d     = '0;
        timer_d   = '0;
        state_d   = INPUT;
      end

      INPUT: begin
        // A press in the same cycle as the final tick wins over the timeout
        if (btn_valid) begin
          if (btn_sym == cur_sym) begin
            if (last_idx) begin
              state_d = ROUND_OK;
            end else begin
              idx_d     = idx_q + LEN_ONE;
              lfsr_step = 1'b1;
              timer_d   = '0;
            end
          end else begin
            loser_d = player_q;
            state_d = OVER;
          end
        end else if (tick) begin
          if (timer_q == TIMEOUT_LAST) begin
            loser_d   = player_q;
            timeout_d = 1'b1;
            state_d   = OVER;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      ROUND_OK: begin
        player_d = ~player_q;
        state_d  = SHOW_LOAD;
        // Length grows only after both players have cleared it
        if (player_q) begin
          if (round_len_q == LEN_MAX) begin
            draw_d  = 1'b1;
            state_d = OVER;
          end else begin
            round_len_d = round_len_q + LEN_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      seed_q      <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      round_len_q <= '0;
      player_q    <= 1'b0;
      loser_q     <= 1'b0;
      timeout_q   <= 1'b0;
      draw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      round_len_q <= round_len_d;
      player_q    <= player_d;
      loser_q     <= loser_d;
      timeout_q   <= timeout_d;
      draw_q      <= draw_d;
    end
  end

  // Phase strobes are pure decodes of the registered state
  assign show_valid   = (state_q == SHOW);
  assign show_sym     = show_valid ? cur_sym : '0;
  assign expect_input = (state_q == INPUT);
  assign round_done   = (state_q == ROUND_OK);
  assign game_over    = (state_q == OVER);
  assign player       = player_q;
  assign round_len    = round_len_q;
  assign loser        = loser_q;
  assign timeout_flag = timeout_q;
  assign draw         = draw_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_round_sequencer
//  Description : Directed self-checking bench for lfsr_round_sequencer with
//                MAX_LEN=2. Seed 16'h0001 yields the symbol sequence 2, 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_round_sequencer;

  localparam int SYM_W = 2;
  localparam int LEN_W = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             tick = 1'b0;
  logic             start = 1'b0;
  logic             btn_valid = 1'b0;
  logic [SYM_W-1:0] btn_sym = '0;
  logic             show_valid;
  logic [SYM_W-1:0] show_sym;
  logic             expect_input;
  logic             player;
  logic [LEN_W-1:0] round_len;
  logic             round_done;
  logic             game_over;
  logic             loser;
  logic             timeout_flag;
  logic             draw;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_round_sequencer #(
    .SYM_W         (2),
    .MAX_LEN       (2),
    .SHOW_TICKS    (4),
    .TIMEOUT_TICKS (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .start        (start),
    .btn_valid    (btn_valid),
    .btn_sym      (btn_sym),
    .show_valid   (show_valid),
    .show_sym     (show_sym),
    .expect_input (expect_input),
    .player       (player),
    .round_len    (round_len),
    .round_done   (round_done),
    .game_over    (game_over),
    .loser        (loser),
    .timeout_flag (timeout_flag),
    .draw         (draw)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic press(input logic [SYM_W-1:0] s);
    btn_valid = 1'b1;
    btn_sym   = s;
    cyc();
    btn_valid = 1'b0;
  endtask

  // Reset, then start on the first edge after release; ends in SHOW_LOAD
  task automatic reset_start();
    reset = 1'b1;
    start = 1'b0;
    cyc();
    reset = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // From SHOW_LOAD: run the display phase for len symbols, end in INPUT
  task automatic display_round(input int len);
    cyc();
    tick_n(4 * len);
    cyc();
  endtask

  initial begin
    // ---------------- reset state
    cyc();
    cyc();
    check("rst_show_valid", show_valid, 0);
    check("rst_show_sym", show_sym, 0);
    check("rst_expect", expect_input, 0);
    check("rst_player", player, 0);
    check("rst_round_len", round_len, 0);
    check("rst_round_done", round_done, 0);
    check("rst_game_over", game_over, 0);
    check("rst_loser", loser, 0);
    check("rst_timeout", timeout_flag, 0);
    check("rst_draw", draw, 0);

    // ---------------- first game: perfect play to a draw
    reset = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("load_no_show", show_valid, 0);
    cyc();
    check("show1_valid", show_valid, 1);
    check("show1_sym", show_sym, 2);
    check("show1_len", round_len, 1);
    check("show1_player", player, 0);
    tick_n(3);
    check("show1_held", show_valid, 1);
    check("show1_held_sym", show_sym, 2);
    tick_n(1);
    check("show1_end", show_valid, 0);
    cyc();
    check("p0_expect", expect_input, 1);
    check("p0_player", player, 0);
    press(2);
    check("p0_round_done", round_done, 1);
    check("p0_expect_off", expect_input, 0);
    cyc();
    check("p0_done_pulse", round_done, 0);
    check("p1_player", player, 1);
    check("p1_len", round_len, 1);
    cyc();
    check("p1_show_sym", show_sym, 2);
    tick_n(4);
    cyc();
    check("p1_expect", expect_input, 1);
    press(2);
    check("p1_round_done", round_done, 1);
    cyc();
    check("r2_len", round_len, 2);
    check("r2_player", player, 0);
    cyc();
    check("r2_sym0", show_sym, 2);
    tick_n(4);
    check("r2_sym1_valid", show_valid, 1);
    check("r2_sym1", show_sym, 0);
    press(1);
    check("show_ignores_btn", show_valid, 1);
    check("show_ignores_btn_go", game_over, 0);
    tick_n(4);
    cyc();
    press(2);
    check("r2p0_mid_expect", expect_input, 1);
    press(0);
    check("r2p0_done", round_done, 1);
    cyc();
    check("r2p1_player", player, 1);
    display_round(2);
    press(2);
    press(0);
    check("r2p1_done", round_done, 1);
    cyc();
    check("draw_game_over", game_over, 1);
    check("draw_flag", draw, 1);
    check("draw_timeout", timeout_flag, 0);
    check("draw_len", round_len, 2);
    check("draw_no_expect", expect_input, 0);
    cyc();
    check("over_held", game_over, 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("restart_go", game_over, 0);
    check("restart_draw", draw, 0);
    check("restart_len", round_len, 1);
    check("restart_player", player, 0);

    // ---------------- wrong symbol by player 0
    reset_start();
    display_round(1);
    press(1);
    check("mm_game_over", game_over, 1);
    check("mm_loser", loser, 0);
    check("mm_timeout", timeout_flag, 0);
    check("mm_draw", draw, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("mm_restart_len", round_len, 1);
    check("mm_restart_go", game_over, 0);

    // ---------------- player 1 times out
    reset_start();
    display_round(1);
    press(2);
    cyc();
    display_round(1);
    check("to_expect", expect_input, 1);
    check("to_player", player, 1);
    tick_n(7);
    check("to_still_waiting", expect_input, 1);
    check("to_not_over", game_over, 0);
    tick_n(1);
    check("to_game_over", game_over, 1);
    check("to_loser", loser, 1);
    check("to_flag", timeout_flag, 1);
    check("to_draw", draw, 0);

    // ---------------- press on the 8th tick beats the timeout
    reset_start();
    display_round(1);
    tick_n(7);
    tick      = 1'b1;
    btn_valid = 1'b1;
    btn_sym   = 2;
    cyc();
    tick      = 1'b0;
    btn_valid = 1'b0;
    check("prio_round_done", round_done, 1);
    check("prio_game_over", game_over, 0);
    check("prio_timeout", timeout_flag, 0);

    // ---------------- asynchronous reset in the middle of SHOW
    reset_start();
    cyc();
    tick_n(2);
    check("mid_show_valid", show_valid, 1);
    reset = 1'b1;
    #2;
    check("async_show_valid", show_valid, 0);
    check("async_show_sym", show_sym, 0);
    check("async_len", round_len, 0);
    check("async_player", player, 0);
    cyc();
    reset = 1'b0;
    cyc();
    check("idle_after_rst", show_valid, 0);
    check("idle_after_rst_go", game_over, 0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("reseed_valid", show_valid, 1);
    check("reseed_sym", show_sym, 2);
    check("reseed_len", round_len, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_round_sequencer.md
Name: lfsr_round_sequencer

Overview:
- Game-sequence controller for the timed two-player memory game. Owns a 16-bit seedable Galois LFSR that uses the team's standard taps: feedback from bit 15 is XORed into bits 2, 3 and 5.
- Per game, captures a seed and replays the same pseudo-random symbol sequence for the display phase and for each player's input check.
- Sequences rounds, alternates players, enforces per-symbol input timeout, and reports the game result.
- Sits between the timebase/button debouncers and the display/score logic.

Parameters:
SYM_W, 2, symbol width (4 buttons/lamps)
MAX_LEN, 16, final sequence length; game ends as a draw after both players clear it
SHOW_TICKS, 4, tick pulses each displayed symbol is held
TIMEOUT_TICKS, 8, tick pulses allowed per input symbol
LEN_W, $clog2(MAX_LEN+1), width of length/index counters

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle timebase pulse
start  in  1  start new game (honoured in IDLE/OVER only)
btn_valid  in  1  one-cycle debounced button press
btn_sym  in  SYM_W  pressed button code
show_valid  out  1  display phase, show_sym is valid
show_sym  out  SYM_W  symbol to display
expect_input  out  1  waiting for a press from the current player
player  out  1  current player (0/1)
round_len  out  LEN_W  current sequence length
round_done  out  1  one-cycle pulse when a player clears a round
game_over  out  1  game finished; held until the next start
loser  out  1  losing player, valid when game_over && !draw
timeout_flag  out  1  the loss was caused by timeout
draw  out  1  both players cleared MAX_LEN

Behaviour:
- Reset (async): state=IDLE, lfsr=16'h0001, seed=0, idx=0, timer=0. All outputs are 0, including round_len.
- next(x): one Galois step of x. The current symbol is always lfsr[SYM_W-1:0].
- IDLE: lfsr<=next(lfsr) every clock (entropy).
  - On start: seed<=lfsr (the value before this edge's step), round_len<=1, player<=0; clear game_over, loser, timeout_flag and draw; go to SHOW_LOAD.
- SHOW_LOAD (1 cycle): lfsr<=next(seed), idx<=0, timer<=0; go to SHOW.
- SHOW: show_valid=1, show_sym=lfsr[SYM_W-1:0].
  - Each tick increments timer. When a tick arrives with timer==SHOW_TICKS-1:
    - if idx==round_len-1, go to INPUT_LOAD;
    - otherwise idx++, lfsr<=next(lfsr), timer<=0.
- INPUT_LOAD (1 cycle): lfsr<=next(seed), idx<=0, timer<=0; go to INPUT.
- INPUT: expect_input=1; expected symbol = lfsr[SYM_W-1:0].
  - On btn_valid with a match:
    - if idx==round_len-1, go to ROUND_OK;
    - otherwise idx++, lfsr<=next(lfsr), timer<=0.
  - On btn_valid with a mismatch: go to OVER with loser=player.
  - If a tick arrives with timer==TIMEOUT_TICKS-1 and no btn_valid in that cycle: go to OVER with loser=player, timeout_flag=1.
  - btn_valid takes priority over the timeout when both occur in the same cycle.
- ROUND_OK (1 cycle): round_done=1, player<=~player.
  - When player was 1: if round_len==MAX_LEN, go to OVER with draw=1; otherwise round_len++.
  - Unless the game ended, go to SHOW_LOAD.
- OVER: game_over=1. Outputs hold; lfsr free-runs. On start, behave exactly as start in IDLE.
- Ignored inputs: start outside IDLE/OVER; btn_valid outside INPUT; tick outside SHOW/INPUT.
- show_valid, expect_input and round_done are decoded from registered state. They assert in the cycle after the transition edge and have no combinational input-to-output path.
- Reset mid-game returns to IDLE immediately. No partial result is reported.

Decomposition:
- Shared package: state enum (IDLE, SHOW_LOAD, SHOW, INPUT_LOAD, INPUT, ROUND_OK, OVER), LFSR tap mask 16'h002C, LFSR reset value 16'h0001.
- Sub-module lfsr16_load: 16-bit LFSR with load/load_val/step enables, same taps, async reset to 16'h0001. The controller drives load with next(seed) or uses step.

Test Plan:
- Reset, then start on the first edge -> seed=16'h0001. SHOW with show_sym=2 held for 4 ticks, then expect_input=1, player=0, round_len=1.
- Player 0 presses 2 -> round_done pulse, player=1, round_len=1, display repeats sym 2. Player 1 presses 2 -> round_len=2; displayed sequence is 2 then 0.
- In INPUT expecting 2, btn_sym=1 -> game_over=1, loser=player, timeout_flag=0, draw=0. A later start restarts at round_len=1.
- No press for 8 ticks -> game_over=1, timeout_flag=1. Repeat with the correct btn_valid in the same cycle as the 8th tick -> press accepted, no timeout.
- Assert reset mid-SHOW -> all outputs 0 asynchronously. After release, the state is IDLE and a start captures seed 16'h0001.
- MAX_LEN=2, both players answer perfectly -> game_over=1, draw=1 after player 1 clears length 2. btn_valid during SHOW is ignored.
